// File: rtl/sif_mem_if.sv
// -----------------------------------------------------------------------------
// sif_mem_if
// Bus bundle between the X-side / W-side agents and the sif_mem operand store.
//
// Signals:
//   xa_wr_s     X write strobe                      (master -> slave)
//   xa_rd_s     X read strobe                       (master -> slave)
//   xa_addr     X address, MSB selects bank (0=X, 1=W)
//   xa_data_wr  X write data                        (master -> slave)
//   xa_data_rd  X read data, registered in sif_mem  (slave -> master)
//   wa_wr_s     W write strobe                      (master -> slave)
//   wa_addr     W address, MSB ignored              (master -> slave)
//   wa_data_wr  W write data                        (master -> slave)
//
// Modports: master (agents / testbench side), slave (sif_mem side).
// -----------------------------------------------------------------------------
interface sif_mem_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              xa_wr_s;
  logic              xa_rd_s;
  logic [ADDR_W-1:0] xa_addr;
  logic [DATA_W-1:0] xa_data_wr;
  logic [DATA_W-1:0] xa_data_rd;
  logic              wa_wr_s;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data_wr;

  modport master (
    output xa_wr_s, xa_rd_s, xa_addr, xa_data_wr,
    output wa_wr_s, wa_addr, wa_data_wr,
    input  xa_data_rd
  );

  modport slave (
    input  xa_wr_s, xa_rd_s, xa_addr, xa_data_wr,
    input  wa_wr_s, wa_addr, wa_data_wr,
    output xa_data_rd
  );
endinterface

// File: rtl/sif_mem.sv
// -----------------------------------------------------------------------------
// sif_mem
// Dual-bank local operand store. The X agent reads both banks and writes only
// the X bank; the W agent writes only the W bank. Read data is registered and
// holds its value between reads.
//
// Ports:
//   clk    single clock, rising edge
//   rst_b  synchronous reset, ACTIVE HIGH despite the name; clears read data
//          and every entry of both banks
//   bus    sif_mem_if.slave bundle (X read/write port, W write port)
//
// Parameters:
//   ADDR_W  address width of both ports
//   DATA_W  data width of both ports
//   DEPTH   words per bank, power of two, <= 2**(ADDR_W-1)
//
// Optional feature macro: SIF_WR_FWD_EN
//   defined   - a read in the same cycle as a write to the same bank/index
//               returns the new write data
//   undefined - same-cycle read returns the previously stored value
// -----------------------------------------------------------------------------
module sif_mem #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic       clk,
  input  logic       rst_b,
  sif_mem_if.slave   bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Both banks must be fully cleared by reset, so they are plain register
  // arrays rather than block RAM.
  logic [DATA_W-1:0] xmem_q [DEPTH];
  logic [DATA_W-1:0] wmem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rd_d;

  logic [IDX_W-1:0]  x_idx;
  logic [IDX_W-1:0]  w_idx;
  logic              x_bank;

  // Bits between the index and the bank bit are don't-care (address aliasing),
  // as is the W-port bank bit.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{bus.xa_addr, bus.wa_addr};

  assign x_idx  = bus.xa_addr[IDX_W-1:0];
  assign w_idx  = bus.wa_addr[IDX_W-1:0];
  assign x_bank = bus.xa_addr[ADDR_W-1];

  // Read data selection.
  always_comb begin
    rd_d = x_bank ? wmem_q[x_idx] : xmem_q[x_idx];
`ifdef SIF_WR_FWD_EN
    // The X write shares the X address, so an X write to the X bank always
    // hits the same index being read.
    if (!x_bank && bus.xa_wr_s) begin
      rd_d = bus.xa_data_wr;
    end else if (x_bank && bus.wa_wr_s && (w_idx == x_idx)) begin
      rd_d = bus.wa_data_wr;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        xmem_q[i] <= '0;
        wmem_q[i] <= '0;
      end
    end else begin
      // X writes aimed at the W bank are dropped.
      if (bus.xa_wr_s && !x_bank) begin
        xmem_q[x_idx] <= bus.xa_data_wr;
      end
      if (bus.wa_wr_s) begin
        wmem_q[w_idx] <= bus.wa_data_wr;
      end
      if (bus.xa_rd_s) begin
        rd_q <= rd_d;
      end
    end
  end

  assign bus.xa_data_rd = rd_q;

endmodule

// File: tb/tb_sif_mem.sv
// -----------------------------------------------------------------------------
// tb_sif_mem
// Directed vector table for the documented scenarios, then randomized traffic
// checked against a bank-array reference model.
// -----------------------------------------------------------------------------
module tb_sif_mem;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;

`ifdef SIF_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  sif_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sif_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic        xw;
    logic        xr;
    logic [15:0] xa;
    logic [15:0] xd;
    logic        ww;
    logic [15:0] wa;
    logic [15:0] wd;
    logic        chk;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic rst, input logic xw, input logic xr,
                     input logic [15:0] xa, input logic [15:0] xd,
                     input logic ww, input logic [15:0] wa, input logic [15:0] wd,
                     input logic chk, input logic [15:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.xw = xw; v.xr = xr; v.xa = xa; v.xd = xd;
    v.ww = ww; v.wa = wa; v.wd = wd; v.chk = chk; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, clock it, sample 1 time unit after the edge.
  task automatic step(input logic rst, input logic xw, input logic xr,
                      input logic [15:0] xa, input logic [15:0] xd,
                      input logic ww, input logic [15:0] wa, input logic [15:0] wd);
    rst_b          = rst;
    bus.xa_wr_s    = xw;
    bus.xa_rd_s    = xr;
    bus.xa_addr    = xa;
    bus.xa_data_wr = xd;
    bus.wa_wr_s    = ww;
    bus.wa_addr    = wa;
    bus.wa_data_wr = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] exp);
    n_tests++;
    if (bus.xa_data_rd !== exp) begin
      n_fail++;
      $display("FAIL %s: xa_data_rd=0x%04h expected 0x%04h", name, bus.xa_data_rd, exp);
    end else begin
      $display("[TB] ok   %s: xa_data_rd=0x%04h", name, bus.xa_data_rd);
    end
  endtask

  // Reference model: two word arrays plus the last value returned.
  logic [15:0] m_x [DEPTH];
  logic [15:0] m_w [DEPTH];
  logic [15:0] m_rd;

  initial begin
    rst_b = 1'b1;
    bus.xa_wr_s = 0; bus.xa_rd_s = 0; bus.xa_addr = 0; bus.xa_data_wr = 0;
    bus.wa_wr_s = 0; bus.wa_addr = 0; bus.wa_data_wr = 0;

    //   rst xw xr  xa       xd       ww  wa       wd       chk exp
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000, "reset_c1");
    add(1, 1, 1, 16'h0005, 16'h9999, 1, 16'h0005, 16'h8888, 1, 16'h0000, "reset_c2_discard");
    add(0, 0, 1, 16'h0005, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000, "rd_x_after_reset");
    add(0, 0, 1, 16'h8005, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000, "rd_w_after_reset");
    add(0, 1, 0, 16'h0010, 16'hA5A5, 0, 16'h0000, 16'h0000, 0, 16'h0000, "x_wr");
    add(0, 0, 1, 16'h0010, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'hA5A5, "x_wr_then_rd");
    add(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0003, 16'h1234, 0, 16'h0000, "w_wr");
    add(0, 0, 1, 16'h8003, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h1234, "w_visible_via_x");
    add(0, 0, 1, 16'h0003, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000, "bank_isolation");
    add(0, 1, 0, 16'h8007, 16'hFFFF, 0, 16'h0000, 16'h0000, 0, 16'h0000, "x_wr_w_region");
    add(0, 0, 1, 16'h8007, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000, "x_wr_w_ignored");
    add(0, 1, 0, 16'h0020, 16'h1111, 0, 16'h0000, 16'h0000, 0, 16'h0000, "wr_old");
    add(0, 1, 1, 16'h0020, 16'h2222, 0, 16'h0000, 16'h0000, 1,
        FWD ? 16'h2222 : 16'h1111, "same_cycle_wr_rd");
    add(0, 0, 1, 16'h0020, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h2222, "rd_after_wr_rd");
    add(0, 1, 0, 16'h0001, 16'h00AA, 1, 16'h0001, 16'h00BB, 0, 16'h0000, "dual_wr");
    add(0, 0, 1, 16'h0001, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h00AA, "dual_wr_x");
    add(0, 0, 1, 16'h8001, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h00BB, "dual_wr_w");
    add(1, 0, 1, 16'h0001, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000, "reset_mid_read");
    add(0, 0, 1, 16'h8001, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000, "banks_cleared");
    add(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0002, 16'h5555, 0, 16'h0000, "w_wr2");
    add(0, 0, 1, 16'h8002, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h5555, "w_rd2");
    add(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h5555, "hold_no_rd");
    add(0, 0, 1, 16'h8009, 16'h0000, 1, 16'h8009, 16'h7777, 1,
        FWD ? 16'h7777 : 16'h0000, "w_fwd_same_cycle");
    add(0, 0, 1, 16'h8209, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h7777, "alias_rd");
    add(0, 1, 0, 16'h7F09, 16'hC3C3, 0, 16'h0000, 16'h0000, 0, 16'h0000, "alias_wr");
    add(0, 0, 1, 16'h0009, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'hC3C3, "alias_wr_rd");

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].xw, vecs[i].xr, vecs[i].xa, vecs[i].xd,
           vecs[i].ww, vecs[i].wa, vecs[i].wd);
      if (vecs[i].chk) check(vecs[i].name, vecs[i].exp);
    end

    // Randomized traffic against the model, starting from a reset.
    for (int c = 0; c < 600; c++) begin
      logic        r, xw, xr, ww;
      logic [15:0] xa, xd, wa, wd, v;
      int unsigned xi, wi;
      r  = (c == 0) || ($urandom_range(0, 59) == 0);
      xw = $urandom_range(0, 1);
      xr = $urandom_range(0, 2) != 0;
      ww = $urandom_range(0, 1);
      // Small index range for frequent hits; random upper bits exercise aliasing.
      xa = 16'($urandom);
      xa[7:0] = 8'($urandom_range(0, 7));
      wa = 16'($urandom);
      wa[7:0] = 8'($urandom_range(0, 7));
      xd = 16'($urandom);
      wd = 16'($urandom);
      xi = xa % DEPTH;
      wi = wa % DEPTH;

      if (r) begin
        for (int k = 0; k < DEPTH; k++) begin
          m_x[k] = '0;
          m_w[k] = '0;
        end
        m_rd = '0;
      end else begin
        if (xr) begin
          v = xa[15] ? m_w[xi] : m_x[xi];
          if (FWD && !xa[15] && xw) v = xd;
          if (FWD && xa[15] && ww && (wi == xi)) v = wd;
          m_rd = v;
        end
        if (xw && !xa[15]) m_x[xi] = xd;
        if (ww) m_w[wi] = wd;
      end

      step(r, xw, xr, xa, xd, ww, wa, wd);
      check($sformatf("rand_%0d", c), m_rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sif_mem.md
# sif_mem

Dual-bank storage interface between the X-side agent (read/write) and the W-side agent (write-only). The block holds an X bank and a W bank of DEPTH words each. X reads reach both banks and return registered data; W writes only update the W bank. It sits between the X and W bus interfaces and the compute datapath, as the local operand store.

## Interface
- ADDR_W, 16, address width of both ports
- DATA_W, 16, data width of both ports
- DEPTH, 256, words per bank; power of two, ≤ 2^(ADDR_W-1)
- clk  input  1  single clock; all logic on rising edge
- rst_b  input  1  reset, synchronous and active-high (asserted when 1), despite the `_b` name
- xa_wr_s  input  1  X write strobe
- xa_rd_s  input  1  X read strobe
- xa_addr  input  ADDR_W  X address; bit ADDR_W-1 selects bank (0 = X, 1 = W)
- xa_data_wr  input  DATA_W  X write data
- xa_data_rd  output  DATA_W  X read data, registered
- wa_wr_s  input  1  W write strobe
- wa_addr  input  ADDR_W  W address; bit ADDR_W-1 ignored
- wa_data_wr  input  DATA_W  W write data

## Operation
- Word index is addr[log2(DEPTH)-1:0]. Bits between the index and the bank-select bit are ignored, so addresses alias.
- X write (xa_wr_s=1):
  - bank bit 0: X bank[idx] ← xa_data_wr.
  - bank bit 1: ignored. The W bank is not writable from X.
- W write (wa_wr_s=1): W bank[idx] ← wa_data_wr.
- X read (xa_rd_s=1): xa_data_rd ← selected bank[idx] at the next edge.
- With xa_rd_s=0, xa_data_rd holds its last value.
- xa_wr_s and xa_rd_s both high in one cycle: both are performed. Read data follows the Configuration rule.
- X and W writes in the same cycle go to different banks, so they never conflict. Both take effect.
- No handshake or back-pressure. Every strobe is accepted in the cycle it is asserted.
- Strobes are level-sensitive: one operation per cycle while high.

## Timing
- Reset (rst_b=1 at a rising edge):
  - xa_data_rd = 0.
  - All entries of both banks = 0.
  - Writes and reads in that cycle are discarded.
- Reset is checked before all other logic. Asserting it mid-operation aborts pending reads, and the next xa_data_rd is 0.
- Write latency: 1 cycle. Data is visible to a read issued in the following cycle.
- Read latency: 1 cycle. With the address presented at edge N, xa_data_rd is valid after edge N+1 and stays stable until the next read or reset.
- Reset release: the first operation is accepted at the first edge with rst_b=0.

## Configuration
- SIF_WR_FWD_EN defined:
  - A read issued in the same cycle as a write to the same bank and index returns the new write data, from whichever of X or W writes that bank.
  - Forwarding compares bank and index only, so aliased addresses also forward.
- Not defined:
  - Same-cycle read returns the old stored value (read-before-write).
  - The new value is returned by a read issued in the following cycle.

## Test plan
- Reset: hold rst_b=1 for 2 cycles, then read X addr 0x0005 and W addr 0x8005 -> xa_data_rd = 0x0000 for both.
- X write then read: write 0xA5A5 at 0x0010, then read 0x0010 next cycle -> xa_data_rd = 0xA5A5 one cycle after the read strobe.
- W write visible via X: wa write 0x1234 at wa_addr 0x0003, then X read 0x8003 -> 0x1234. X read of 0x0003 -> 0x0000 (bank isolation).
- X write to W region ignored: X write 0xFFFF at 0x8007, then read 0x8007 -> 0x0000.
- Same-cycle write+read at 0x0020 (old 0x1111, new 0x2222):
  - with SIF_WR_FWD_EN -> 0x2222;
  - without -> 0x1111, then 0x2222 on the next read.
- Simultaneous writes: X writes 0x00AA at 0x0001 while W writes 0x00BB at 0x0001 -> reads of 0x0001 = 0x00AA and 0x8001 = 0x00BB. Then assert rst_b mid-read -> xa_data_rd = 0.
